// File: rtl/trace_capture_unit.sv
// Retire-trace capture buffer with cycle/retire counters, halt detection and a retire watchdog.
// Optional macro TRACE_REGS_EN adds a register snapshot to every trace entry.
module trace_capture_unit #(
  parameter int PC_W        = 8,
  parameter int INSTR_W     = 20,
  parameter int DATA_W      = 8,
  parameter int NUM_REGS    = 4,
  parameter int DEPTH       = 16,
  parameter int WDOG_CYCLES = 100,
  parameter int WRAP_MODE   = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         arm,
  input  logic                         retire_valid,
  input  logic [PC_W-1:0]              pc_in,
  input  logic [INSTR_W-1:0]           instr_in,
  input  logic                         halt_in,
  input  logic [NUM_REGS*DATA_W-1:0]   regs_in,
  input  logic                         rd_en,
  output logic                         rd_valid,
  output logic [PC_W-1:0]              rd_pc,
  output logic [INSTR_W-1:0]           rd_instr,
  output logic [NUM_REGS*DATA_W-1:0]   rd_regs,
  output logic [$clog2(DEPTH):0]       count,
  output logic [31:0]                  cycle_cnt,
  output logic [31:0]                  retire_cnt,
  output logic [1:0]                   state_out,
  output logic                         done,
  output logic                         timeout,
  output logic                         overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int RW = NUM_REGS * DATA_W;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CAPTURE = 2'd1,
    S_HALTED  = 2'd2,
    S_TIMEOUT = 2'd3
  } state_t;

  state_t         state, state_nxt;
  logic [AW-1:0]  wptr, rptr;
  logic [31:0]    wdog;
  logic           capturing, full, do_pop, do_ret, do_write, lose, wdog_expire;

  logic [PC_W-1:0]    pc_mem    [DEPTH];
  logic [INSTR_W-1:0] instr_mem [DEPTH];

  // Handshake: rd_en pops the oldest entry only when count>0; rd_valid and rd_* follow one cycle later.
  always_comb begin
    capturing   = (state == S_CAPTURE) && !arm;
    full        = (count == CW'(DEPTH));
    do_pop      = rd_en && (count != '0) && !arm;
    do_ret      = capturing && retire_valid;
    do_write    = do_ret && (!full || do_pop || (WRAP_MODE != 0));
    lose        = do_ret && full && !do_pop;
    wdog_expire = (WDOG_CYCLES != 0) && !retire_valid && ((wdog + 32'd1) == 32'(WDOG_CYCLES));
  end

  always_comb begin
    state_nxt = state;
    if (arm) begin
      state_nxt = S_CAPTURE;
    end else if (state == S_CAPTURE) begin
      if (halt_in)          state_nxt = S_HALTED;
      else if (wdog_expire) state_nxt = S_TIMEOUT;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      wptr       <= '0;
      rptr       <= '0;
      count      <= '0;
      wdog       <= '0;
      cycle_cnt  <= '0;
      retire_cnt <= '0;
      overflow   <= 1'b0;
      rd_valid   <= 1'b0;
      rd_pc      <= '0;
      rd_instr   <= '0;
    end else begin
      state    <= state_nxt;
      rd_valid <= do_pop;
      if (arm) begin
        wptr       <= '0;
        rptr       <= '0;
        count      <= '0;
        wdog       <= '0;
        cycle_cnt  <= '0;
        retire_cnt <= '0;
        overflow   <= 1'b0;
      end else begin
        if (do_pop) begin
          rd_pc    <= pc_mem[rptr];
          rd_instr <= instr_mem[rptr];
        end
        // In wrap mode a write into a full buffer lands on the oldest slot, so the read side skips it.
        if (do_pop || (lose && (WRAP_MODE != 0))) rptr <= rptr + AW'(1);
        if (do_write) wptr <= wptr + AW'(1);
        if (do_write && !do_pop && !full)  count <= count + CW'(1);
        else if (do_pop && !do_write)      count <= count - CW'(1);
        if (capturing) begin
          if (cycle_cnt != '1) cycle_cnt <= cycle_cnt + 32'd1;
          if (retire_valid) begin
            if (retire_cnt != '1) retire_cnt <= retire_cnt + 32'd1;
            wdog <= '0;
          end else if (wdog != '1) begin
            wdog <= wdog + 32'd1;
          end
          if (lose) overflow <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_write) begin
      pc_mem[wptr]    <= pc_in;
      instr_mem[wptr] <= instr_in;
    end
  end

`ifdef TRACE_REGS_EN
  logic [RW-1:0] regs_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (do_write) regs_mem[wptr] <= regs_in;
  end

  always_ff @(posedge clk) begin
    if (rst)                rd_regs <= '0;
    else if (do_pop)        rd_regs <= regs_mem[rptr];
  end
`else
  logic unused_regs;
  assign unused_regs = ^regs_in;
  assign rd_regs     = '0;
`endif

  assign state_out = state;
  assign done      = (state == S_HALTED);
  assign timeout   = (state == S_TIMEOUT);
endmodule

// File: doc/trace_capture_unit.md
Name: trace_capture_unit

Overview:
- Parametrised retire-trace and run-control monitor that sits beside processor_top.
- Snoops retire events (PC, instruction, optional register snapshot) into a circular trace buffer.
- Counts cycles and retired instructions, detects halt, and flags a watchdog timeout when retirement stalls.
- Successor to the fixed 8-bit/20-bit/4-register debug taps; generalised in PC, instruction and data widths, register count, depth and overflow mode.

Parameters:
- PC_W, 8, program counter width
- INSTR_W, 20, instruction width
- DATA_W, 8, register width
- NUM_REGS, 4, number of snooped registers
- DEPTH, 16, trace entries; power of two, ≥2
- WDOG_CYCLES, 100, CAPTURE cycles without a retire before timeout; 0 disables the watchdog
- WRAP_MODE, 1, 1 = overwrite oldest entry when full; 0 = drop newest entry when full

Ports:
- clk  in  1  single clock; all logic on posedge
- rst  in  1  synchronous, active-high reset
- arm  in  1  pulse; clear buffer and counters, then start capture
- retire_valid  in  1  one instruction retired this cycle
- pc_in  in  PC_W  PC of the retired instruction
- instr_in  in  INSTR_W  retired instruction word
- halt_in  in  1  processor halt indication
- regs_in  in  NUM_REGS*DATA_W  register file, R0 in the LSBs
- rd_en  in  1  pop the oldest entry
- rd_valid  out  1  rd_* outputs valid this cycle
- rd_pc  out  PC_W  popped PC
- rd_instr  out  INSTR_W  popped instruction
- rd_regs  out  NUM_REGS*DATA_W  popped register snapshot
- count  out  $clog2(DEPTH)+1  entries held
- cycle_cnt  out  32  cycles spent in CAPTURE, saturating
- retire_cnt  out  32  retires seen in CAPTURE, saturating; includes dropped retires
- state_out  out  2  0 IDLE, 1 CAPTURE, 2 HALTED, 3 TIMEOUT
- done  out  1  high in HALTED
- timeout  out  1  high in TIMEOUT
- overflow  out  1  sticky; an entry was lost

Behaviour:
- Reset: state IDLE; all outputs 0; read/write pointers 0; watchdog 0. Reset mid-capture discards the buffer.
- arm is honoured in any state. The next cycle is CAPTURE with count, cycle_cnt, retire_cnt, overflow, watchdog and pointers all 0. A retire in the arm cycle is not captured. arm while in CAPTURE restarts capture.
- IDLE: retire_valid and halt_in are ignored.
- CAPTURE, per cycle:
  - cycle_cnt += 1.
  - On retire_valid: write {pc_in, instr_in, regs_in} at the write pointer, retire_cnt += 1, clear the watchdog.
  - Without a retire: watchdog += 1.
- Full buffer plus retire, no simultaneous pop:
  - WRAP_MODE=1: overwrite the oldest entry and advance the read pointer; count stays DEPTH; set overflow.
  - WRAP_MODE=0: discard the new entry; set overflow.
- Full buffer plus retire plus pop: the pop takes the oldest entry, the write succeeds, count is unchanged, no overflow.
- CAPTURE → HALTED on halt_in. A retire in the same cycle is captured.
- CAPTURE → TIMEOUT when the watchdog reaches WDOG_CYCLES (WDOG_CYCLES≠0). If halt_in and expiry land in the same cycle, HALTED wins.
- HALTED and TIMEOUT: counters freeze; the state is held until arm or rst.
- Readout is legal in every state. rd_en with count>0 pops the oldest entry; rd_valid=1 and the data appear the next cycle (1-cycle latency). rd_valid is a single-cycle pulse per pop.
- rd_en with count=0 is ignored: rd_valid=0 and the rd_* outputs hold.
- Write and pop in the same non-full cycle: count is unchanged.
- Pointers wrap modulo DEPTH. Counters saturate at 32'hFFFF_FFFF.

Optional Feature:
- Macro TRACE_REGS_EN.
- Defined: each entry stores the regs_in snapshot and rd_regs returns it.
- Undefined: no register storage is built, rd_regs is tied to 0, and regs_in is unused.
- All other behaviour is identical in both builds.

Test Plan:
- Reset, arm, 5 retires with PC 00..04 and instr 10000..10004, then 5 pops → rd_pc 00..04 in order; count goes 5→0; retire_cnt=5.
- WRAP_MODE=1, DEPTH=16, 20 retires with PC 00..13, then drain → rd_pc 04..13; overflow=1; retire_cnt=20.
- WRAP_MODE=0, same stimulus → rd_pc 00..0F; overflow=1; count=16 before the drain.
- 3 retires then halt_in with a retire in the same cycle → state_out=2, done=1, count=4; cycle_cnt frozen; a later arm clears everything to CAPTURE.
- WDOG_CYCLES=10, arm, no retires → timeout=1 and state_out=3 after exactly 10 CAPTURE cycles. Halt and expiry in the same cycle → state_out=2.
- TRACE_REGS_EN defined, regs_in=32'h04030201 on a retire → popped rd_regs=32'h04030201. Undefined → rd_regs=0. rd_en on an empty buffer → rd_valid stays 0.
